// File: rtl/click_pkg.sv
// click_pkg: record layout and collector FSM states
// shared by the click collector and its FIFO.
package click_pkg;

  localparam int REC_W    = 32;
  localparam int CH_MSB   = 31;
  localparam int CH_LSB   = 29;
  localparam int TIME_MSB = 28;
  localparam int TIME_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WAIT_LOW
  } state_t;

endpackage

// File: rtl/click_fifo.sv
// click_fifo: synchronous first-word-fall-through FIFO.
// Ports: i_push/i_data write, i_pop read, o_valid/o_data head, o_full, o_count.
module click_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_count = r_cnt;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & o_valid;
  // Head reads as zero when empty so out_data is clean after reset.
  assign o_data  = o_valid ? r_mem[r_rp] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/click_collector.sv
// click_collector: synchronises click-register ready flags, grants round-robin,
// queues records in a FIFO and pulses clear; records leave as a valid/ready stream.
module click_collector
  import click_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         click_ready,
  input  logic [NCH*REC_W-1:0]   click_data,
  output logic [NCH-1:0]         click_clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REC_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
  logic [NCH-1:0]   w_rdy_s;
  logic [NCH-1:0]   w_blocked;
  logic [NCH-1:0]   w_req;
  logic [NCH-1:0]   r_clear;
  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_g;
  logic [CW-1:0]    r_last;
  logic [CW-1:0]    w_pick;
  logic [CW-1:0]    w_idx;
  logic             w_hit;
  logic             w_grant;
  logic             w_full;
  logic [REC_W-1:0] w_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], click_ready};
  end

  assign w_rdy_s   = r_sync[SYNC_STAGES-1];
  // The channel being serviced is masked until it is back in IDLE.
  assign w_blocked = (r_state == IDLE) ? '0 : (NCH'(1) << r_g);
  assign w_req     = w_rdy_s & ~w_blocked;

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_last;
    w_idx  = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = CW'((int'(r_last) + i) % NCH);
      if (!w_hit && w_req[w_idx]) begin
        w_hit  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_pick == CW'(k)) w_wdata = click_data[k*REC_W +: REC_W];
    end
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit && !w_full) begin
          w_grant = 1'b1;
          w_next  = CLEAR;
        end
      end
      CLEAR:    w_next = WAIT_LOW;
      WAIT_LOW: if (!w_rdy_s[r_g]) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_g     <= LAST_CH;
      r_last  <= LAST_CH;
      r_clear <= '0;
    end else begin
      r_state <= w_next;
      r_clear <= w_grant ? (NCH'(1) << w_pick) : '0;
      if (w_grant) r_g <= w_pick;
      if (r_state == WAIT_LOW && w_next == IDLE) r_last <= r_g;
    end
  end

  assign click_clear = r_clear;
  assign busy        = (r_state != IDLE);

  click_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant),
    .i_data  (w_wdata),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_count (fifo_level)
  );

endmodule

// File: tb/tb_click_collector.sv
// tb_click_collector: directed bench with a behavioural click-register model
// and a stream consumer log.
module tb_click_collector;

  localparam int NCH   = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   click_ready;
  logic [NCH*32-1:0] click_data;
  logic [NCH-1:0]   click_clear;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [4:0]       fifo_level;
  logic             busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] rx[$];
  logic [7:0]  clr[$];

  logic [NCH-1:0] rdy = '0;
  logic [31:0] base[NCH] = '{default: 32'h0};
  int seq[NCH]        = '{default: 0};
  int kick_cnt[NCH]   = '{default: 0};
  int kick_seen[NCH]  = '{default: 0};
  int rearm_n[NCH]    = '{default: 0};
  int rearm_used[NCH] = '{default: 0};
  int dcnt[NCH]       = '{default: 0};
  int rcnt[NCH]       = '{default: 0};
  int fall_dly = 0;

  always #5 clk = ~clk;

  assign click_ready = rdy;
  for (genvar k = 0; k < NCH; k++) begin : g_dat
    assign click_data[32*k +: 32] = base[k] + 32'(seq[k]);
  end

  click_collector #(
    .NCH         (NCH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .click_ready (click_ready),
    .click_data  (click_data),
    .click_clear (click_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  // Click registers: ready drops fall_dly cycles after clear, optionally re-arms.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) rx.push_back(out_data);
      if (click_clear != '0) clr.push_back(click_clear);
    end
    for (int k = 0; k < NCH; k++) begin
      if (kick_cnt[k] != kick_seen[k]) begin
        kick_seen[k] = kick_cnt[k];
        rdy[k] = 1'b1;
      end
      if (click_clear[k]) dcnt[k] = fall_dly + 1;
      if (dcnt[k] > 0) begin
        dcnt[k]--;
        if (dcnt[k] == 0) begin
          rdy[k] = 1'b0;
          if (rearm_used[k] < rearm_n[k]) begin
            rearm_used[k]++;
            rcnt[k] = 3;
          end
        end
      end else if (rcnt[k] > 0) begin
        rcnt[k]--;
        if (rcnt[k] == 0) begin
          seq[k]++;
          rdy[k] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rxat(int i);
    return (i < rx.size()) ? rx[i] : 32'hDEAD0000;
  endfunction

  function automatic logic [31:0] clrat(int i);
    return (i < clr.size()) ? 32'(clr[i]) : 32'hDEAD0000;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int b;
    int c;
    int viol;
    int n0;
    int n7;
    int lvl_ok;
    int seen;
    logic [31:0] exp;

    cyc(3);
    check("rst_clear", 32'(click_clear), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc(2);

    // single event on channel 3
    b = rx.size();
    c = clr.size();
    base[3] = 32'h6ABCDEF1;
    kick_cnt[3]++;
    cyc(20);
    check("one_n", 32'(rx.size() - b), 1);
    check("one_data", rxat(b), 32'h6ABCDEF1);
    check("one_clr_n", 32'(clr.size() - c), 1);
    check("one_clr", clrat(c), 32'h08);
    check("one_busy", 32'(busy), 0);

    // simultaneous ready on 0, 2, 7 after reset
    do_reset();
    b = rx.size();
    c = clr.size();
    base[0] = {3'd0, 29'h00000A0};
    base[2] = {3'd2, 29'h00000A2};
    base[7] = {3'd7, 29'h00000A7};
    kick_cnt[0]++;
    kick_cnt[2]++;
    kick_cnt[7]++;
    cyc(40);
    check("sim_n", 32'(rx.size() - b), 3);
    check("sim_r0", rxat(b), {3'd0, 29'h00000A0});
    check("sim_r1", rxat(b + 1), {3'd2, 29'h00000A2});
    check("sim_r2", rxat(b + 2), {3'd7, 29'h00000A7});
    check("sim_c0", clrat(c), 32'h01);
    check("sim_c1", clrat(c + 1), 32'h04);
    check("sim_c2", clrat(c + 2), 32'h80);

    // fairness between channels 1 and 2, 20 events
    do_reset();
    b = rx.size();
    base[1] = {3'd1, 29'h0000100};
    base[2] = {3'd2, 29'h0000200};
    seq[1] = 0;
    seq[2] = 0;
    rearm_n[1] = rearm_used[1] + 9;
    rearm_n[2] = rearm_used[2] + 9;
    kick_cnt[1]++;
    kick_cnt[2]++;
    cyc(200);
    check("fair_n", 32'(rx.size() - b), 20);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      exp = (i % 2 == 0) ? base[1] : base[2];
      exp = exp + 32'(i / 2);
      if (rxat(b + i) !== exp) viol++;
    end
    check("fair_order", 32'(viol), 0);

    // full FIFO: 19 events with the consumer stalled
    out_ready = 1'b0;
    b = rx.size();
    c = clr.size();
    for (int k = 0; k < NCH; k++) begin
      base[k] = {3'(k), 29'h0000300};
      rearm_n[k] = rearm_used[k] + ((k < 3) ? 2 : 1);
    end
    for (int k = 0; k < NCH; k++) kick_cnt[k]++;
    lvl_ok = 0;
    for (int i = 0; i < 400 && lvl_ok == 0; i++) begin
      cyc(1);
      if (fifo_level == 5'(DEPTH)) lvl_ok = 1;
    end
    check("full_reach", 32'(lvl_ok), 1);
    cyc(40);
    check("full_level", 32'(fifo_level), DEPTH);
    check("full_clr_n", 32'(clr.size() - c), DEPTH);
    check("full_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    cyc(200);
    check("drain_n", 32'(rx.size() - b), DEPTH + 3);
    check("drain_level", 32'(fifo_level), 0);
    check("drain_clr_n", 32'(clr.size() - c), DEPTH + 3);
    n0 = 0;
    n7 = 0;
    for (int i = b; i < rx.size(); i++) begin
      if (rx[i][31:29] == 3'd0) n0++;
      if (rx[i][31:29] == 3'd7) n7++;
    end
    check("drain_ch0", 32'(n0), 3);
    check("drain_ch7", 32'(n7), 2);
    check("drain_busy", 32'(busy), 0);

    // slow ready fall: one record only
    fall_dly = 5;
    b = rx.size();
    c = clr.size();
    base[5] = {3'd5, 29'h0000555};
    kick_cnt[5]++;
    cyc(40);
    exp = base[5] + 32'(seq[5]);
    check("slow_n", 32'(rx.size() - b), 1);
    check("slow_data", rxat(b), exp);
    check("slow_clr_n", 32'(clr.size() - c), 1);
    check("slow_busy", 32'(busy), 0);
    fall_dly = 0;

    // reset while clear is being driven
    out_ready = 1'b0;
    c = clr.size();
    base[4] = {3'd4, 29'h0000444};
    kick_cnt[4]++;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cyc(1);
      if (click_clear != '0) seen = 1;
    end
    check("rc_seen", 32'(seen), 1);
    check("rc_pulse", 32'(click_clear), 32'h10);
    check("rc_valid_pre", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rc_clear", 32'(click_clear), 0);
    check("rc_valid", 32'(out_valid), 0);
    check("rc_level", 32'(fifo_level), 0);
    check("rc_busy", 32'(busy), 0);
    cyc(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    b = rx.size();
    cyc(30);
    exp = base[4] + 32'(seq[4]);
    check("rc_n", 32'(rx.size() - b), 1);
    check("rc_data", rxat(b), exp);
    check("rc_clr_n", 32'(clr.size() - c), 1);
    check("rc_clr", clrat(c), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
